// File: rtl/mymultiplier_axi_sequencer_if.sv
// mymultiplier_axi_sequencer_if: AXI4-Lite bundle between the sequencer and the MYMULTIPLIER slave
interface mymultiplier_axi_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mymultiplier_axi_sequencer.sv
// mymultiplier_axi_sequencer: round-robin AXI4-Lite master sharing one multiplier between two requesters
module mymultiplier_axi_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic req0_valid,
  output logic req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic req1_valid,
  output logic req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic rsp_id,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data,
  output logic rsp_err,
  mymultiplier_axi_sequencer_if.master m_axi
);
  typedef enum logic [2:0] {IDLE, WR_A, B_A, WR_B, B_B, RD_AR, RD_R, RSP} state_t;
  state_t state, nxt;
  logic last_grant, aw_done, w_done, grant1, accept;
  logic wr, aw_ok, w_ok, wr_fin, b_hs, b_ok;
  logic [15:0] op_a, op_b;
  assign grant1 = req1_valid && !(req0_valid && last_grant);
  assign req0_ready = state == IDLE && req0_valid && !grant1;
  assign req1_ready = state == IDLE && grant1;
  assign accept = req0_ready || req1_ready;
  assign wr = state == WR_A || state == WR_B;
  assign aw_ok = aw_done || (m_axi.awvalid && m_axi.awready);
  assign w_ok = w_done || (m_axi.wvalid && m_axi.wready);
  assign wr_fin = wr && aw_ok && w_ok;
  assign b_hs = m_axi.bvalid && m_axi.bready;
  assign b_ok = m_axi.bresp == 2'b00;
  assign m_axi.awaddr = state == WR_A ? C_BASE_ADDR :
                        state == WR_B ? C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4) : '0;
  assign m_axi.awprot = 3'b000;
  assign m_axi.awvalid = wr && !aw_done;
  assign m_axi.wdata = wr ? C_M_AXI_DATA_WIDTH'(state == WR_B ? op_b : op_a) : '0;
  assign m_axi.wstrb = '1;
  assign m_axi.wvalid = wr && !w_done;
  assign m_axi.bready = state == B_A || state == B_B;
  assign m_axi.araddr = state == RD_AR ? C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(8) : '0;
  assign m_axi.arprot = 3'b000;
  assign m_axi.arvalid = state == RD_AR;
  assign m_axi.rready = state == RD_R;
  assign rsp_valid = state == RSP;
  always_ff @(posedge ACLK)
    if (ARESET) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = accept ? WR_A : IDLE;
      WR_A:  nxt = wr_fin ? B_A : WR_A;
      B_A:   nxt = b_hs ? (b_ok ? WR_B : RSP) : B_A;
      WR_B:  nxt = wr_fin ? B_B : WR_B;
      B_B:   nxt = b_hs ? (b_ok ? RD_AR : RSP) : B_B;
      RD_AR: nxt = m_axi.arready ? RD_R : RD_AR;
      RD_R:  nxt = m_axi.rvalid ? RSP : RD_R;
      RSP:   nxt = rsp_ready ? IDLE : RSP;
    endcase
  end
  always_ff @(posedge ACLK)
    if (ARESET) begin
      last_grant <= 1'b1;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      rsp_id <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
    end else begin
      aw_done <= wr && !wr_fin && aw_ok;
      w_done <= wr && !wr_fin && w_ok;
      if (accept) begin
        op_a <= grant1 ? req1_a : req0_a;
        op_b <= grant1 ? req1_b : req0_b;
        rsp_id <= grant1;
        rsp_err <= 1'b0;
        rsp_data <= '0;
      end
      if (b_hs && !b_ok) rsp_err <= 1'b1;
      if (state == RD_R && m_axi.rvalid) begin
        rsp_data <= m_axi.rresp == 2'b00 ? m_axi.rdata : '0;
        if (m_axi.rresp != 2'b00) rsp_err <= 1'b1;
      end
      if (state == RSP && rsp_ready) last_grant <= rsp_id;
    end
endmodule

// File: doc/mymultiplier_axi_sequencer.md
# mymultiplier_axi_sequencer

AXI4-Lite master that shares one MYMULTIPLIER slave between two local requesters. It arbitrates requests round-robin and, for each request, writes operand A and operand B to the multiplier registers. It then reads back the product and returns it with the requester ID and an error flag. It sits between the fabric-side logic and the MYMULTIPLIER S00_AXI port, replacing the BFM master used in block-design simulation.

## Interface
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width; fixed at 32.
- C_BASE_ADDR, 32'h0000_0000: multiplier base. Register map: A at +0x0, B at +0x4, product at +0x8.

- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request from requester 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  in  16  operands; zero-extended to 32 on write.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester served.
- rsp_data  out  32  product read from +0x8; 0 on error.
- rsp_err  out  1  any BRESP/RRESP not OKAY.
- M_AXI_AWADDR  out  32.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  32.
- M_AXI_WSTRB  out  4  constant 4'hF.
- M_AXI_WVALID  out  1.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2.
- M_AXI_BVALID  in  1.
- M_AXI_BREADY  out  1.
- M_AXI_ARADDR  out  32.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  32.
- M_AXI_RRESP  in  2.
- M_AXI_RVALID  in  1.
- M_AXI_RREADY  out  1.

## Operation
- FSM states: IDLE, WR_A, B_A, WR_B, B_B, RD_AR, RD_R, RSP.
- IDLE: arbitrate when any reqN_valid is high.
  - Assert the winner's reqN_ready for one cycle.
  - Latch its operands and ID.
  - Go to WR_A.
- Arbitration: round-robin on last_grant.
  - Single request always wins.
  - Both requests: grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- WR_A / WR_B: AWVALID and WVALID rise together.
  - AWADDR = base+0x0 or base+0x4.
  - WDATA = {16'h0, operand}.
  - Each valid drops independently after its own handshake.
  - Leave the state when both handshakes are done; they may occur in any order or in the same cycle.
- B_A / B_B: BREADY high.
  - On BVALID with BRESP==OKAY, advance.
  - Otherwise set err and go to RSP, skipping the remaining accesses.
- RD_AR: ARVALID high with ARADDR = base+0x8; advance on ARREADY.
- RD_R: RREADY high; on RVALID, capture RDATA.
  - RRESP!=OKAY sets err and forces data to 0.
- RSP: rsp_valid high; rsp_id, rsp_data and rsp_err stay stable until rsp_ready.
  - On handshake, update last_grant and go to IDLE.
  - No request is accepted while in RSP.
- AXI address and data outputs hold stable while their valid is high.
- Exactly one outstanding AXI transaction at any time.

## Timing
- Reset values:
  - All VALID and READY outputs, reqN_ready and rsp_valid are 0.
  - rsp_data, rsp_id, rsp_err, AWADDR, WDATA and ARADDR are 0.
  - FSM in IDLE; last_grant = 1.
- Reset is honoured in any state, including mid-handshake: every valid drops on the same edge and any in-flight transaction is abandoned. The slave shares ARESET, so no recovery is needed.
- Request accept to rsp_valid is 7 cycles minimum, for a slave that gives ready in the same cycle as valid and B/R one cycle later:
  - accept C0; WR_A C1; B_A C2; WR_B C3; B_B C4; RD_AR C5; RD_R C6; RSP C7.
- Each wait cycle on AWREADY, WREADY, BVALID, ARREADY or RVALID adds exactly one cycle.
- reqN_ready is combinational from IDLE state and reqN_valid only; no path from AXI inputs.
- Back-to-back: the cycle after the RSP handshake is IDLE and can accept a new request.

## Test plan
- Single request: req0 a=3, b=5 -> AW 0x0 / W 0x3, AW 0x4 / W 0x5, AR 0x8. rsp_id=0, rsp_data=15, rsp_err=0, rsp_valid at accept+7 with a zero-wait slave.
- Contention: both requests held with a=0x00FF, b=0x0101 (req0) and a=0x1234, b=2 (req1) -> responses id0 (0xFFFF), id1 (0x2468), id0, id1, alternating.
- Backpressure:
  - WREADY 2 cycles after WVALID, AWREADY 4 cycles after AWVALID -> WVALID drops after its handshake, AWVALID holds, exactly one write per operand.
  - rsp_ready held low 5 cycles -> rsp_valid and payload stable, req0_ready and req1_ready low.
- Error: BRESP=2'b10 on the operand-B write -> no AR issued, rsp_err=1, rsp_data=0, next request completes normally.
- Reset mid-op: ARESET asserted in RD_R with RVALID low -> next cycle all outputs at reset values; the first tie after reset goes to requester 0.
- Wide operands: req1 a=0xFFFF, b=0xFFFF -> WDATA 0x0000FFFF both times, rsp_data=0xFFFE0001.
